// File: rtl/mips_pkg.sv
// Shared constants for the memory-stage access path: payload width,
// target-select encodings and the skid-buffer occupancy states.
package mips_pkg;

  localparam int MIPS_WIDTH = 32;

  localparam logic SEL_DMEM = 1'b0;
  localparam logic SEL_IO   = 1'b1;

  // The buffer state is its occupancy, so the debug count is the state itself.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/demux2_skid.sv
// Steers one producer stream to data memory (port 0) or I/O space (port 1)
// through a 2-entry in-order skid buffer that cuts the ready path.
module demux2_skid
  import mips_pkg::*;
#(
  parameter int WIDTH = MIPS_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [1:0]       count
);

  // Handshake: a beat moves on a rising edge where valid and ready are both 1.
  // Valid never waits on ready, and a raised valid holds its data and select
  // steady until that edge. in_ready comes from registers only.

  logic [WIDTH-1:0] data_q [0:1];
  logic             sel_q  [0:1];
  logic             head;
  logic             tail;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             in_ready_q;
  logic             head_sel;
  logic             push;
  logic             pop;

  assign head_sel   = sel_q[head];
  assign out0_valid = (state != ST_EMPTY) & (head_sel == SEL_DMEM);
  assign out1_valid = (state != ST_EMPTY) & (head_sel == SEL_IO);
  assign out0_data  = data_q[head];
  assign out1_data  = data_q[head];
  assign in_ready   = in_ready_q;
  assign count      = state;

  assign push = in_valid & in_ready_q;
  assign pop  = (out0_valid & out0_ready) | (out1_valid & out1_ready);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (push) state_nxt = ST_ONE;
      ST_ONE: begin
        if (push && !pop)      state_nxt = ST_FULL;
        else if (pop && !push) state_nxt = ST_EMPTY;
      end
      ST_FULL:  if (pop) state_nxt = ST_ONE;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q[0]  <= '0;
      data_q[1]  <= '0;
      sel_q[0]   <= 1'b0;
      sel_q[1]   <= 1'b0;
      head       <= 1'b0;
      tail       <= 1'b0;
      state      <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      if (push) begin
        data_q[tail] <= in_data;
        sel_q[tail]  <= in_sel;
        tail         <= ~tail;
      end
      if (pop) head <= ~head;
      state      <= state_nxt;
      in_ready_q <= (state_nxt != ST_FULL);
    end
  end

endmodule

// File: tb/tb_demux2_skid.sv
// Self-checking bench for demux2_skid: directed scenarios plus a
// queue-based reference model checked every cycle.
module tb_demux2_skid;

  localparam int W = 32;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         in_sel;
  logic         out0_valid;
  logic         out0_ready;
  logic [W-1:0] out0_data;
  logic         out1_valid;
  logic         out1_ready;
  logic [W-1:0] out1_data;
  logic [1:0]   count;

  int n_checks = 0;
  int n_fail = 0;
  int n_delivered = 0;
  bit mon_en = 0;

  logic [W:0]   exp_q[$];
  int           m_size;
  logic         e_v0;
  logic         e_v1;
  logic [W-1:0] act_data;
  logic         do_pop;

  demux2_skid #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .count(count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && in_valid === 1'b1)
      assert (!$isunknown(in_sel)) else $error("in_sel is X while in_valid=1");
  end

  // Reference model: a queue of at most two {sel,data} beats. Sampled mid-cycle,
  // it checks the visible state and then applies what the next edge will do.
  always @(negedge clk) begin
    if (mon_en) begin
      m_size = exp_q.size();
      e_v0 = (m_size > 0) && !exp_q[0][W];
      e_v1 = (m_size > 0) && exp_q[0][W];
      n_checks++;
      if (count !== 2'(m_size) || in_ready !== (m_size != 2) ||
          out0_valid !== e_v0 || out1_valid !== e_v1) begin
        n_fail++;
        $display("FAIL model_state: got count=%0d rdy=%0b v0=%0b v1=%0b want count=%0d rdy=%0b v0=%0b v1=%0b",
                 count, in_ready, out0_valid, out1_valid, m_size, (m_size != 2), e_v0, e_v1);
      end
      if (m_size > 0) begin
        act_data = exp_q[0][W] ? out1_data : out0_data;
        n_checks++;
        if (act_data !== exp_q[0][W-1:0]) begin
          n_fail++;
          $display("FAIL model_head_data: got %h want %h", act_data, exp_q[0][W-1:0]);
        end
      end
      if (!reset_n) exp_q.delete();
      else begin
        do_pop = (m_size > 0) && (exp_q[0][W] ? out1_ready : out0_ready);
        if (do_pop) begin
          void'(exp_q.pop_front());
          n_delivered++;
        end
        if (in_valid && m_size < 2) exp_q.push_back({in_sel, in_data});
      end
    end
  end

  // driver: present inputs now, return just after the edge that consumes them
  task automatic tick(input logic v, input logic s, input logic [W-1:0] d,
                      input logic r0, input logic r1);
    in_valid = v; in_sel = s; in_data = d; out0_ready = r0; out1_ready = r1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(1'b1, 1'b0, 32'hdead, 1'b1, 1'b1);
    mon_en = 1;
    tick(1'b1, 1'b0, 32'hbeef, 1'b1, 1'b1);
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valids: got %b%b want 00", out0_valid, out1_valid); end
    n_checks++; if (out0_data !== '0 || out1_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h %h want 0 0", out0_data, out1_data); end
    reset_n = 1'b1;
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_nothing_accepted: got count %0d want 0", count); end
  endtask

  task automatic test_alternating();
    tick(1'b1, 1'b0, 32'hA, 1'b1, 1'b1);
    n_checks++; if (out0_valid !== 1'b1 || out0_data !== 32'hA) begin n_fail++; $display("FAIL alt_beat_a: got v0=%b d=%h want 1 a", out0_valid, out0_data); end
    tick(1'b1, 1'b1, 32'hB, 1'b1, 1'b1);
    n_checks++; if (out1_valid !== 1'b1 || out1_data !== 32'hB || out0_valid !== 1'b0) begin n_fail++; $display("FAIL alt_beat_b: got v1=%b d=%h v0=%b want 1 b 0", out1_valid, out1_data, out0_valid); end
    tick(1'b1, 1'b0, 32'hC, 1'b1, 1'b1);
    n_checks++; if (out0_valid !== 1'b1 || out0_data !== 32'hC || in_ready !== 1'b1) begin n_fail++; $display("FAIL alt_beat_c: got v0=%b d=%h rdy=%b want 1 c 1", out0_valid, out0_data, in_ready); end
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL alt_drain: got count %0d want 0", count); end
  endtask

  task automatic test_full();
    tick(1'b1, 1'b1, 32'h11, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 32'h22, 1'b1, 1'b0);
    n_checks++; if (count !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_state: got count=%0d rdy=%b want 2 0", count, in_ready); end
    tick(1'b1, 1'b0, 32'h33, 1'b1, 1'b0);
    n_checks++; if (count !== 2'd2 || out0_valid !== 1'b0 || out1_data !== 32'h11) begin n_fail++; $display("FAIL full_hol_block: got count=%0d v0=%b d1=%h want 2 0 11", count, out0_valid, out1_data); end
    tick(1'b1, 1'b0, 32'h33, 1'b1, 1'b1);
    n_checks++; if (count !== 2'd1 || out0_valid !== 1'b1 || out0_data !== 32'h22) begin n_fail++; $display("FAIL full_release: got count=%0d v0=%b d0=%h want 1 1 22", count, out0_valid, out0_data); end
    tick(1'b1, 1'b0, 32'h33, 1'b1, 1'b1);
    n_checks++; if (count !== 2'd1 || out0_data !== 32'h33) begin n_fail++; $display("FAIL full_held_beat: got count=%0d d0=%h want 1 33", count, out0_data); end
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_simultaneous();
    tick(1'b1, 1'b0, 32'h5, 1'b0, 1'b1);
    n_checks++; if (count !== 2'd1 || out0_data !== 32'h5) begin n_fail++; $display("FAIL simul_setup: got count=%0d d0=%h want 1 5", count, out0_data); end
    tick(1'b1, 1'b1, 32'h6, 1'b1, 1'b0);
    n_checks++; if (count !== 2'd1 || out1_valid !== 1'b1 || out1_data !== 32'h6) begin n_fail++; $display("FAIL simul_push_pop: got count=%0d v1=%b d1=%h want 1 1 6", count, out1_valid, out1_data); end
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
  endtask

  task automatic test_wrap();
    logic [W-1:0] bd [8];
    logic         bs [8];
    int sent = 0;
    int cyc = 0;
    int base;
    logic acc;
    for (int i = 0; i < 8; i++) begin
      bd[i] = $urandom;
      bs[i] = 1'($urandom_range(0, 1));
    end
    base = n_delivered;
    while ((sent < 8 || n_delivered < base + 8) && cyc < 300) begin
      acc = (sent < 8) && in_ready;
      if (sent < 8)
        tick(1'b1, bs[sent], bd[sent], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        tick(1'b0, 1'b0, 32'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (acc) sent++;
      cyc++;
    end
    n_checks++; if (n_delivered !== base + 8) begin n_fail++; $display("FAIL wrap_delivered: got %0d want %0d (cycle budget)", n_delivered - base, 8); end
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL wrap_empty: got count %0d want 0", count); end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 1'b0, 32'h1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 32'h2, 1'b0, 1'b0);
    n_checks++; if (count !== 2'd2) begin n_fail++; $display("FAIL mid_setup: got count %0d want 2", count); end
    reset_n = 1'b0;
    tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    reset_n = 1'b1;
    n_checks++; if (count !== 2'd0 || out0_valid !== 1'b0 || out1_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset: got count=%0d v0=%b v1=%b rdy=%b want 0 0 0 1", count, out0_valid, out1_valid, in_ready); end
    tick(1'b1, 1'b0, 32'h77, 1'b0, 1'b0);
    n_checks++; if (out0_valid !== 1'b1 || out0_data !== 32'h77 || count !== 2'd1) begin n_fail++; $display("FAIL mid_after: got v0=%b d0=%h count=%0d want 1 77 1", out0_valid, out0_data, count); end
    tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_checks++; if (count !== 2'd0) begin n_fail++; $display("FAIL mid_drain: got count %0d want 0", count); end
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_sel = 1'b0; in_data = '0; out0_ready = 1'b0; out1_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_alternating();
    test_full();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
